// File: rtl/uart_bus_master.sv
// uart_bus_master: turns single CPU register requests into packed AW/W/B or AR/R handshakes.
// Define UART_BUS_MASTER_TIMEOUT_EN to abort stalled transactions with SLVERR after TIMEOUT_CYCLES.
//   state   | meaning
//   IDLE    | ready for a CPU request
//   WR_REQ  | AW and W handshakes pending (complete independently)
//   WR_RESP | bready high, waiting for bvalid
//   RD_REQ  | arvalid high, waiting for arready
//   RD_RESP | rready high, waiting for rvalid
//   RESP    | response held for the CPU until resp_ready
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int BUS_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_addr,
    input  logic [7:0]       req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_rdata,
    output logic [1:0]       resp_err,
    output logic [BUS_W-1:0] bus_o,
    input  logic [BUS_W-1:0] bus_i
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP
    } state_t;

    state_t      state, state_n;
    logic        awvalid, awvalid_n, wvalid, wvalid_n, bready, bready_n;
    logic        arvalid, arvalid_n, rready, rready_n;
    logic [2:0]  awaddr, awaddr_n, araddr, araddr_n;
    logic [7:0]  wdata, wdata_n;
    logic        aw_done, aw_done_n, w_done, w_done_n;
    logic        req_ready_n, resp_valid_n;
    logic [7:0]  resp_rdata_n;
    logic [1:0]  resp_err_n;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // bus_i bits above rdata carry nothing for this master
    logic unused_bits;
    assign unused_bits = ^{bus_i[BUS_W-1:17], (TIMEOUT_CYCLES != 0)};

    assign aw_hs = awvalid & bus_i[0];
    assign w_hs  = wvalid  & bus_i[1];
    assign b_hs  = bready  & bus_i[2];
    assign ar_hs = arvalid & bus_i[5];
    assign r_hs  = rready  & bus_i[6];

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt, cnt_n;
    logic        busy, any_hs;
    assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
`endif

    always_comb begin
        state_n      = state;
        awvalid_n    = awvalid;
        wvalid_n     = wvalid;
        bready_n     = bready;
        arvalid_n    = arvalid;
        rready_n     = rready;
        awaddr_n     = awaddr;
        araddr_n     = araddr;
        wdata_n      = wdata;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        req_ready_n  = req_ready;
        resp_valid_n = resp_valid;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_ready_n = 1'b0;
                    if (req_write) begin
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        awaddr_n  = req_addr;
                        wdata_n   = req_wdata;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                        state_n   = WR_REQ;
                    end else begin
                        arvalid_n = 1'b1;
                        araddr_n  = req_addr;
                        state_n   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    bready_n = 1'b1;
                    state_n  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_n     = 1'b0;
                    resp_err_n   = bus_i[4:3];
                    resp_rdata_n = 8'h00;
                    resp_valid_n = 1'b1;
                    state_n      = RESP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rready_n     = 1'b0;
                    resp_rdata_n = bus_i[16:9];
                    resp_err_n   = bus_i[8:7];
                    resp_valid_n = 1'b1;
                    state_n      = RESP;
                end
            end
            RESP: begin
                if (resp_valid && resp_ready) begin
                    resp_valid_n = 1'b0;
                    req_ready_n  = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        cnt_n = cnt;
        if (!busy || any_hs) begin
            cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
            awvalid_n    = 1'b0;
            wvalid_n     = 1'b0;
            bready_n     = 1'b0;
            arvalid_n    = 1'b0;
            rready_n     = 1'b0;
            resp_err_n   = 2'b10;
            resp_rdata_n = 8'h00;
            resp_valid_n = 1'b1;
            state_n      = RESP;
        end else begin
            cnt_n = cnt + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            araddr     <= '0;
            wdata      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= '0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_n;
            awvalid    <= awvalid_n;
            wvalid     <= wvalid_n;
            bready     <= bready_n;
            arvalid    <= arvalid_n;
            rready     <= rready_n;
            awaddr     <= awaddr_n;
            araddr     <= araddr_n;
            wdata      <= wdata_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            cnt        <= cnt_n;
`endif
        end
    end

    assign bus_o = {12'b0, rready, araddr, arvalid, 1'b0, wdata, bready, awaddr, wvalid, awvalid};

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: scoreboard of expected CPU responses plus bus-level checks.
// Timeout steps are compiled only when UART_BUS_MASTER_TIMEOUT_EN is defined.
module tb_uart_bus_master;

    typedef struct packed {
        logic [7:0] rdata;
        logic [1:0] err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid, resp_ready;
    logic [7:0]  resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] bus_o, bus_i;

    logic        u_awready, u_wready, u_bvalid, u_arready, u_rvalid;
    logic [1:0]  u_bresp, u_rresp;
    logic [7:0]  u_rdata;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    assign bus_i = {15'b0, u_rdata, u_rresp, u_rvalid, u_arready, u_bresp, u_bvalid, u_wready, u_awready};

    uart_bus_master #(.TIMEOUT_CYCLES(16), .BUS_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_o(bus_o), .bus_i(bus_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] rd, input logic [1:0] er);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
    endtask

    task automatic consume_resp(input string tag);
        int   n = 0;
        exp_t e;
        while (resp_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check($sformatf("%s_resp_seen", tag), resp_valid, 1'b1);
        check($sformatf("%s_sb_nonempty", tag), sb.size() > 0, 1'b1);
        if (resp_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s_rdata", tag), resp_rdata, e.rdata);
            check($sformatf("%s_err", tag), resp_err, e.err);
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
            check($sformatf("%s_resp_clear", tag), resp_valid, 1'b0);
            check($sformatf("%s_req_ready", tag), req_ready, 1'b1);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [1:0] br, input string tag);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        push_exp(8'h00, br);
        step();
        req_valid = 1'b0;
        check($sformatf("%s_req_ready_low", tag), req_ready, 1'b0);
        check($sformatf("%s_awvalid", tag), bus_o[0], 1'b1);
        check($sformatf("%s_wvalid", tag), bus_o[1], 1'b1);
        check($sformatf("%s_awaddr", tag), bus_o[4:2], a);
        check($sformatf("%s_wdata", tag), bus_o[13:6], d);
        u_awready = 1'b1; u_wready = 1'b1;
        step();
        u_awready = 1'b0; u_wready = 1'b0;
        check($sformatf("%s_aw_clear", tag), bus_o[1:0], 2'b00);
        check($sformatf("%s_bready", tag), bus_o[5], 1'b1);
        u_bvalid = 1'b1; u_bresp = br;
        step();
        u_bvalid = 1'b0; u_bresp = 2'b00;
        check($sformatf("%s_resp_t3", tag), resp_valid, 1'b1);
        check($sformatf("%s_bready_clear", tag), bus_o[5], 1'b0);
        consume_resp(tag);
    endtask

    task automatic read_to_resp(input logic [2:0] a, input logic [7:0] rd, input logic [1:0] rr, input string tag);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        push_exp(rd, rr);
        step();
        req_valid = 1'b0;
        check($sformatf("%s_arvalid", tag), bus_o[15], 1'b1);
        check($sformatf("%s_araddr", tag), bus_o[18:16], a);
        u_arready = 1'b1;
        step();
        u_arready = 1'b0;
        check($sformatf("%s_ar_clear", tag), bus_o[15], 1'b0);
        check($sformatf("%s_rready", tag), bus_o[19], 1'b1);
        u_rvalid = 1'b1; u_rdata = rd; u_rresp = rr;
        step();
        u_rvalid = 1'b0; u_rdata = 8'h00; u_rresp = 2'b00;
        check($sformatf("%s_resp_t3", tag), resp_valid, 1'b1);
        check($sformatf("%s_rready_clear", tag), bus_o[19], 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        u_awready = 1'b0; u_wready = 1'b0; u_bvalid = 1'b0; u_arready = 1'b0; u_rvalid = 1'b0;
        u_bresp = 2'b00; u_rresp = 2'b00; u_rdata = 8'h00;
        step();
        step();
        check("rst_bus_o", bus_o, 32'h0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 8'h00);
        check("rst_err", resp_err, 2'b00);
        rst = 1'b0;
        step();

        // zero-wait write
        do_write(3'd3, 8'h83, 2'b00, "wr0");

        // staggered write: wready two cycles before awready, bvalid four cycles late
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 8'hC4;
        push_exp(8'h00, 2'b00);
        step();
        req_valid = 1'b0;
        u_wready = 1'b1;
        step();
        u_wready = 1'b0;
        check("stag_wvalid_drop", bus_o[1], 1'b0);
        check("stag_awvalid_hold", bus_o[0], 1'b1);
        check("stag_awaddr_hold", bus_o[4:2], 3'd5);
        check("stag_bready_early", bus_o[5], 1'b0);
        step();
        check("stag_awvalid_hold2", bus_o[0], 1'b1);
        check("stag_bready_early2", bus_o[5], 1'b0);
        u_awready = 1'b1;
        step();
        u_awready = 1'b0;
        check("stag_awvalid_drop", bus_o[0], 1'b0);
        check("stag_bready", bus_o[5], 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stag_bready_wait", bus_o[5], 1'b1);
            check("stag_no_resp", resp_valid, 1'b0);
        end
        u_bvalid = 1'b1; u_bresp = 2'b00;
        step();
        u_bvalid = 1'b0;
        consume_resp("stag");

        // read with one-cycle arready delay and stray inputs while in RD_REQ
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd7;
        push_exp(8'h5A, 2'b00);
        step();
        req_valid = 1'b0;
        u_rvalid = 1'b1; u_rdata = 8'hEE; u_awready = 1'b1; u_bvalid = 1'b1;
        step();
        u_rvalid = 1'b0; u_rdata = 8'h00; u_awready = 1'b0; u_bvalid = 1'b0;
        check("rd7_stray_arvalid", bus_o[15], 1'b1);
        check("rd7_stray_no_resp", resp_valid, 1'b0);
        check("rd7_araddr", bus_o[18:16], 3'd7);
        u_arready = 1'b1;
        step();
        u_arready = 1'b0;
        check("rd7_rready", bus_o[19], 1'b1);
        u_rvalid = 1'b1; u_rdata = 8'h5A; u_rresp = 2'b00;
        step();
        u_rvalid = 1'b0; u_rdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            check("rd7_hold_valid", resp_valid, 1'b1);
            check("rd7_hold_rdata", resp_rdata, 8'h5A);
            check("rd7_hold_req_ready", req_ready, 1'b0);
            step();
        end
        consume_resp("rd7");

        // error passthrough
        read_to_resp(3'd1, 8'h33, 2'b10, "rderr");
        consume_resp("rderr");
        do_write(3'd6, 8'h0F, 2'b11, "wrerr");

        // reset while waiting in WR_RESP: no response for the abandoned write
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_wdata = 8'h99;
        step();
        req_valid = 1'b0;
        u_awready = 1'b1; u_wready = 1'b1;
        step();
        u_awready = 1'b0; u_wready = 1'b0;
        check("mid_bready", bus_o[5], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bus_o", bus_o, 32'h0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("mid_no_resp", resp_valid, 1'b0);
        read_to_resp(3'd4, 8'hC3, 2'b00, "postrst");
        // a request held during the response handshake must not be taken that cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
        consume_resp("postrst");
        check("b2b_not_taken", bus_o[15], 1'b0);
        push_exp(8'h11, 2'b01);
        step();
        req_valid = 1'b0;
        check("b2b_arvalid", bus_o[15], 1'b1);
        check("b2b_araddr", bus_o[18:16], 3'd2);
        u_arready = 1'b1;
        step();
        u_arready = 1'b0;
        u_rvalid = 1'b1; u_rdata = 8'h11; u_rresp = 2'b01;
        step();
        u_rvalid = 1'b0; u_rdata = 8'h00; u_rresp = 2'b00;
        consume_resp("b2b");

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0;
        push_exp(8'h00, 2'b10);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("to_arvalid_hold", bus_o[15], 1'b1);
            check("to_no_resp_yet", resp_valid, 1'b0);
            step();
        end
        check("to_arvalid_drop", bus_o, 32'h0);
        check("to_resp", resp_valid, 1'b1);
        u_rvalid = 1'b1; u_rdata = 8'h77; u_rresp = 2'b00;
        step();
        u_rvalid = 1'b0; u_rdata = 8'h00;
        check("to_late_rvalid_rdata", resp_rdata, 8'h00);
        consume_resp("to");
        u_rvalid = 1'b1; u_rdata = 8'h77;
        step();
        u_rvalid = 1'b0; u_rdata = 8'h00;
        step();
        check("to_late_rvalid_idle", resp_valid, 1'b0);
        check("to_late_req_ready", req_ready, 1'b1);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
